// File: rtl/aeolus_mc_core.sv
// aeolus_mc_core: tiny accumulator micro-controller with a 4-bit opcode program memory.
//
// Ports:
//   clk        - single clock, all state changes on its rising edge
//   reset      - asynchronous, active-low reset
//   start      - begin execution from IDLE/HALTED, or advance one instruction from PAUSE
//   step_mode  - 1 = pause after every executed instruction
//   sw_a/sw_b  - operand sources for LDA/LDB, sampled on the EXEC edge
//   prog_we    - program-memory write enable (honoured only in IDLE/HALTED)
//   prog_addr  - program-memory write address
//   prog_data  - program-memory write data (one 4-bit opcode)
//   cpu_out    - O register
//   carry      - carry/borrow flag
//   busy       - 1 in FETCH/EXEC/PAUSE
//   halted     - 1 only in HALTED
//   pc         - program counter

module aeolus_mc_core #(
    parameter int unsigned DATA_W = 4,
    parameter int unsigned PC_W   = 4
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic              step_mode,
    input  logic [DATA_W-1:0] sw_a,
    input  logic [DATA_W-1:0] sw_b,
    input  logic              prog_we,
    input  logic [PC_W-1:0]   prog_addr,
    input  logic [3:0]        prog_data,
    output logic [DATA_W-1:0] cpu_out,
    output logic              carry,
    output logic              busy,
    output logic              halted,
    output logic [PC_W-1:0]   pc
);

    localparam int unsigned Depth = 2 ** PC_W;

    typedef enum logic [2:0] {
        StIdle,
        StFetch,
        StExec,
        StPause,
        StHalted
    } state_e;

    typedef enum logic [3:0] {
        OpNop  = 4'h0,
        OpLda  = 4'h1,
        OpLdb  = 4'h2,
        OpLdo  = 4'h3,
        OpAdd  = 4'h4,
        OpSub  = 4'h5,
        OpAnd  = 4'h6,
        OpOr   = 4'h7,
        OpXor  = 4'h8,
        OpInv  = 4'h9,
        OpLsh  = 4'hA,
        OpRsh  = 4'hB,
        OpClr  = 4'hC,
        OpSnz  = 4'hD,
        OpMova = 4'hE,
        OpHalt = 4'hF
    } op_e;

    // Program memory is deliberately outside the reset domain so programs survive reset.
    logic [3:0] mem [Depth];

    state_e            state_q, state_d;
    logic [PC_W-1:0]   pc_q, pc_d;
    op_e               ir_q, ir_d;
    logic [DATA_W-1:0] a_q, a_d;
    logic [DATA_W-1:0] b_q, b_d;
    logic [DATA_W-1:0] acc_q, acc_d;
    logic [DATA_W-1:0] o_q, o_d;
    logic              carry_q, carry_d;

    logic [DATA_W:0]   sum;
    logic [DATA_W:0]   diff;
    logic              mem_we;

    // One extra bit holds carry-out for ADD and borrow (A < B) for SUB.
    assign sum  = {1'b0, a_q} + {1'b0, b_q};
    assign diff = {1'b0, a_q} - {1'b0, b_q};

    assign mem_we = prog_we && ((state_q == StIdle) || (state_q == StHalted));

    always_ff @(posedge clk) begin
        if (mem_we) begin
            mem[prog_addr] <= prog_data;
        end
    end

    always_comb begin
        state_d = state_q;
        pc_d    = pc_q;
        ir_d    = ir_q;
        a_d     = a_q;
        b_d     = b_q;
        acc_d   = acc_q;
        o_d     = o_q;
        carry_d = carry_q;

        unique case (state_q)
            StIdle, StHalted: begin
                if (start) begin
                    state_d = StFetch;
                    pc_d    = '0;
                end
            end
            StFetch: begin
                // A write on the start edge has already landed, so this read sees it.
                ir_d    = op_e'(mem[pc_q]);
                state_d = StExec;
            end
            StExec: begin
                pc_d = pc_q + PC_W'(1);
                case (ir_q)
                    OpNop: ;
                    OpLda: a_d = sw_a;
                    OpLdb: b_d = sw_b;
                    OpLdo: o_d = acc_q;
                    OpAdd: begin
                        acc_d   = sum[DATA_W-1:0];
                        carry_d = sum[DATA_W];
                    end
                    OpSub: begin
                        acc_d   = diff[DATA_W-1:0];
                        carry_d = diff[DATA_W];
                    end
                    OpAnd: acc_d = a_q & b_q;
                    OpOr:  acc_d = a_q | b_q;
                    OpXor: acc_d = a_q ^ b_q;
                    OpInv: acc_d = ~a_q;
                    OpLsh: begin
                        acc_d   = {acc_q[DATA_W-2:0], 1'b0};
                        carry_d = acc_q[DATA_W-1];
                    end
                    OpRsh: begin
                        acc_d   = {1'b0, acc_q[DATA_W-1:1]};
                        carry_d = acc_q[0];
                    end
                    OpClr: begin
                        acc_d   = '0;
                        carry_d = 1'b0;
                    end
                    OpSnz: begin
                        if (acc_q != '0) begin
                            pc_d = pc_q + PC_W'(2);
                        end
                    end
                    OpMova: a_d = acc_q;
                    OpHalt: pc_d = pc_q;
                endcase

                if (ir_q == OpHalt) begin
                    state_d = StHalted;
                end else if (step_mode) begin
                    state_d = StPause;
                end else begin
                    state_d = StFetch;
                end
            end
            StPause: begin
                if (start) begin
                    state_d = StFetch;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= StIdle;
            pc_q    <= '0;
            ir_q    <= OpNop;
            a_q     <= '0;
            b_q     <= '0;
            acc_q   <= '0;
            o_q     <= '0;
            carry_q <= 1'b0;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            ir_q    <= ir_d;
            a_q     <= a_d;
            b_q     <= b_d;
            acc_q   <= acc_d;
            o_q     <= o_d;
            carry_q <= carry_d;
        end
    end

    assign cpu_out = o_q;
    assign carry   = carry_q;
    assign busy    = (state_q == StFetch) || (state_q == StExec) || (state_q == StPause);
    assign halted  = (state_q == StHalted);
    assign pc      = pc_q;

endmodule
